// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Each port
//   hands over an operation on a valid/ready handshake. Ties between the two
//   ports are broken round-robin. The accepted operands are registered and
//   drive the ALU for one cycle, and the captured result is returned on the
//   owning port's response handshake.
//
//   Every operation takes at least three cycles (IDLE -> EXEC -> RESP). No new
//   operation is accepted while one is in flight.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/reqN_ready     request handshake for port N (ready is combinational in IDLE)
//   reqN_a, reqN_b, reqN_ctr  operands and ALUctr code for port N
//   respN_valid/respN_ready   response handshake for port N
//   resp_result/zero/ovf/err  shared captured response data
//   alu_a, alu_b, alu_ctr     drive to the external ALU (addu of zeros outside EXEC)
//   alu_result/zero/ovf       external ALU outputs
//
// Configuration
//   ALU_ARB_CHECK_EN  when defined, an ALUctr code outside the legal set is not
//                     sent through the ALU result path: the response is 0 with
//                     resp_err set. When undefined, resp_err is always 0.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_ctr,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_ctr,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_ovf,
  output logic        resp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_b_q;
  logic [3:0]  op_ctr_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [31:0] result_q;
  logic        zero_q, ovf_q, err_q;

  logic        accept;
  logic        grant;
  logic [31:0] result_d;
  logic        zero_d, ovf_d, err_d;

  // Arbitration, handshakes and ALU drive
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    grant       = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctr     = 4'b0001;
    unique case (state_q)
      IDLE: begin
        // Reset has priority over acceptance, so ready is masked while rst is high.
        if (!rst && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          grant      = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          req0_ready = ~grant;
          req1_ready = grant;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        alu_a   = op_a_q;
        alu_b   = op_b_q;
        alu_ctr = op_ctr_q;
        state_d = RESP;
      end
      RESP: begin
        resp0_valid = ~owner_q;
        resp1_valid = owner_q;
        if (owner_q ? resp1_ready : resp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Value captured at the end of EXEC
  always_comb begin
    result_d = alu_result;
    zero_d   = alu_zero;
    ovf_d    = alu_ovf;
    err_d    = 1'b0;
`ifdef ALU_ARB_CHECK_EN
    unique case (op_ctr_q)
      4'b1110, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011,
      4'b0111, 4'b1010, 4'b1000, 4'b1001, 4'b0110: ;
      default: begin
        result_d = '0;
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        err_d    = 1'b1;
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctr_q     <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_a_q       <= grant ? req1_a   : req0_a;
        op_b_q       <= grant ? req1_b   : req0_b;
        op_ctr_q     <= grant ? req1_ctr : req0_ctr;
        owner_q      <= grant;
        last_grant_q <= grant;
      end
      if (state_q == EXEC) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        ovf_q    <= ovf_d;
        err_q    <= err_d;
      end
    end
  end

  assign resp_result = result_q;
  assign resp_zero   = zero_q;
  assign resp_ovf    = ovf_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctr, req1_ctr;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready, resp1_ready;
  logic [31:0] resp_result;
  logic        resp_zero, resp_ovf, resp_err;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctr;
  logic        alu_zero, alu_ovf;
  logic [33:0] alu_out;

  int checks = 0;
  int errors = 0;
  int exp_last;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctr(req0_ctr),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctr(req1_ctr),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_ovf(resp_ovf), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
  );

  // Behavioural ALU: returns {ovf, zero, result}
  function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    logic [31:0] r;
    logic        o;
    longint      s;
    o = 1'b0;
    case (c)
      4'b1110: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0100: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0001: r = a + b;
      4'b0101: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0111: r = a ^ b;
      4'b1010: r = b << a[4:0];
      4'b1000: r = b >> a[4:0];
      4'b1001: r = $signed(b) >>> a[4:0];
      4'b0110: r = {b[15:0], 16'h0000};
      default: r = 32'hDEADBEEF;
    endcase
    return {o, (r == 32'd0), r};
  endfunction

  assign alu_out    = alu_fn(alu_a, alu_b, alu_ctr);
  assign alu_result = alu_out[31:0];
  assign alu_zero   = alu_out[32];
  assign alu_ovf    = alu_out[33];

  logic [3:0] legal_codes [11] = '{4'b1110, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011,
                                   4'b0111, 4'b1010, 4'b1000, 4'b1001, 4'b0110};

  // Expected response: {err, ovf, zero, result}
  function automatic logic [34:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    bit legal;
    legal = 1'b0;
    foreach (legal_codes[i]) if (legal_codes[i] == c) legal = 1'b1;
`ifdef ALU_ARB_CHECK_EN
    if (!legal) return {1'b1, 34'd0};
`endif
    return {1'b0, alu_fn(a, b, c)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] c);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctr = c;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctr = c;
    end
  endtask

  task automatic expect_grant(input int p, input string tag);
    #1;
    check(tag, {30'd0, req1_ready, req0_ready}, (p == 0) ? 32'd1 : 32'd2);
  endtask

  // Called in the IDLE cycle whose edge is the handshake; leaves the bench in
  // the following IDLE cycle. Response readies are whatever the caller set.
  task automatic finish_op(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input string tag);
    logic [34:0] e;
    e = ref_op(a, b, c);
    tick();
    check({tag, ".exec_alu_a"}, alu_a, a);
    check({tag, ".exec_alu_b"}, alu_b, b);
    check({tag, ".exec_alu_ctr"}, {28'd0, alu_ctr}, {28'd0, c});
    check({tag, ".exec_no_resp"}, {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check({tag, ".exec_no_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    check({tag, ".resp_valid"}, {30'd0, resp1_valid, resp0_valid}, (p == 0) ? 32'd1 : 32'd2);
    check({tag, ".result"}, resp_result, e[31:0]);
    check({tag, ".zero"}, {31'd0, resp_zero}, {31'd0, e[32]});
    check({tag, ".ovf"}, {31'd0, resp_ovf}, {31'd0, e[33]});
    check({tag, ".err"}, {31'd0, resp_err}, {31'd0, e[34]});
    tick();
    check({tag, ".resp_done"}, {30'd0, resp1_valid, resp0_valid}, 32'd0);
    exp_last = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] qa0 [4], qb0 [4], qa1 [4], qb1 [4];
    logic [3:0]  qc0 [4], qc1 [4];
    logic [31:0] ba, bb, held;
    int i0, i1, p;

    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rst.resp_valid", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    check("rst.result", resp_result, 32'd0);
    check("rst.flags", {29'd0, resp_zero, resp_ovf, resp_err}, 32'd0);
    check("rst.alu_a", alu_a, 32'd0);
    check("rst.alu_ctr", {28'd0, alu_ctr}, 32'd1);
    rst = 1'b0;
    exp_last = 1;
    tick();
    check("idle.ready_none", {30'd0, req1_ready, req0_ready}, 32'd0);

    // Port 0 only: 7 + 5
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    set_req(0, 1'b1, 32'd7, 32'd5, 4'b1110);
    expect_grant(0, "p0add.grant");
    finish_op(0, 32'd7, 32'd5, 4'b1110, "p0add");
    set_req(0, 1'b0, '0, '0, '0);
    check("p0add.result_value", resp_result, 32'd12);

    // Port 1 signed sub overflow, then unsigned sub without overflow
    set_req(1, 1'b1, 32'h80000000, 32'd1, 4'b0100);
    expect_grant(1, "p1sub.grant");
    finish_op(1, 32'h80000000, 32'd1, 4'b0100, "p1sub");
    check("p1sub.ovf_value", {31'd0, resp_ovf}, 32'd1);
    check("p1sub.result_value", resp_result, 32'h7FFFFFFF);
    set_req(1, 1'b1, 32'h80000000, 32'd1, 4'b0101);
    expect_grant(1, "p1subu.grant");
    finish_op(1, 32'h80000000, 32'd1, 4'b0101, "p1subu");
    check("p1subu.ovf_value", {31'd0, resp_ovf}, 32'd0);
    set_req(1, 1'b0, '0, '0, '0);

    // Both ports continuously valid, 4 random ops each
    for (int k = 0; k < 4; k++) begin
      qa0[k] = $urandom; qb0[k] = $urandom; qc0[k] = legal_codes[$urandom_range(0, 10)];
      qa1[k] = $urandom; qb1[k] = $urandom; qc1[k] = legal_codes[$urandom_range(0, 10)];
    end
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 8; k++) begin
      if (i0 < 4) set_req(0, 1'b1, qa0[i0], qb0[i0], qc0[i0]);
      else        set_req(0, 1'b0, '0, '0, '0);
      if (i1 < 4) set_req(1, 1'b1, qa1[i1], qb1[i1], qc1[i1]);
      else        set_req(1, 1'b0, '0, '0, '0);
      if (i0 < 4 && i1 < 4) p = (exp_last == 0) ? 1 : 0;
      else                  p = (i1 < 4) ? 1 : 0;
      expect_grant(p, "rr.grant");
      if (p == 0) begin
        finish_op(0, qa0[i0], qb0[i0], qc0[i0], "rr.p0");
        i0++;
      end else begin
        finish_op(1, qa1[i1], qb1[i1], qc1[i1], "rr.p1");
        i1++;
      end
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);

    // Backpressure on port 0 with port 1 waiting
    ba = $urandom;
    bb = $urandom;
    resp0_ready = 1'b0;
    set_req(0, 1'b1, ba, bb, 4'b0111);
    expect_grant(0, "bp.grant0");
    tick();
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 32'd3, 32'd9, 4'b0011);
    tick();
    held = ba ^ bb;
    for (int k = 0; k < 5; k++) begin
      check("bp.resp0_held", {31'd0, resp0_valid}, 32'd1);
      check("bp.result_held", resp_result, held);
      check("bp.req1_blocked", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    resp0_ready = 1'b1;
    #1;
    check("bp.release_valid", {31'd0, resp0_valid}, 32'd1);
    tick();
    exp_last = 0;
    expect_grant(1, "bp.grant1");
    finish_op(1, 32'd3, 32'd9, 4'b0011, "bp.p1");
    set_req(1, 1'b0, '0, '0, '0);

    // Reset while an op is in EXEC
    set_req(0, 1'b1, 32'd100, 32'd23, 4'b0001);
    expect_grant(0, "rexec.grant");
    tick();
    rst = 1'b1;
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0001);
    #1;
    tick();
    check("rexec.ready_in_rst", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("rexec.result_cleared", resp_result, 32'd0);
    tick();
    check("rexec.no_resp", {30'd0, resp1_valid, resp0_valid}, 32'd0);
    rst = 1'b0;
    exp_last = 1;
    expect_grant(0, "rexec.tie_port0");
    finish_op(0, 32'd100, 32'd23, 4'b0001, "rexec.p0");
    set_req(0, 1'b0, '0, '0, '0);
    expect_grant(1, "rexec.p1_after");
    finish_op(1, 32'd1, 32'd2, 4'b0001, "rexec.p1");
    set_req(1, 1'b0, '0, '0, '0);

    // Illegal ALUctr code
    set_req(0, 1'b1, 32'h12345678, 32'h0F0F0F0F, 4'b1111);
    expect_grant(0, "ill.grant");
    finish_op(0, 32'h12345678, 32'h0F0F0F0F, 4'b1111, "ill");
    set_req(0, 1'b0, '0, '0, '0);
`ifdef ALU_ARB_CHECK_EN
    check("ill.err_value", {31'd0, resp_err}, 32'd1);
`else
    check("ill.err_value", {31'd0, resp_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
